// File: rtl/cndm_pcie_cfg_ext_vsec_if.sv
// Bus bundle between the PCIe core cfg_ext port, the VSEC responder and the
// management-side mailbox. The slave view is the responder; the master view is everything around it.
interface cndm_pcie_cfg_ext_vsec_if;
   logic        cfg_ext_read_received;
   logic        cfg_ext_write_received;
   logic [9:0]  cfg_ext_register_number;
   logic [7:0]  cfg_ext_function_number;
   logic [31:0] cfg_ext_write_data;
   logic [3:0]  cfg_ext_write_byte_enable;
   logic [31:0] cfg_ext_read_data;
   logic        cfg_ext_read_data_valid;
   logic [31:0] mbox_req_data;
   logic        mbox_req_valid;
   logic        mbox_req_ready;
   logic [31:0] mbox_resp_data;
   logic        mbox_resp_valid;
   logic        mbox_resp_ready;
   logic        irq;

   modport slave (
      input  cfg_ext_read_received, cfg_ext_write_received, cfg_ext_register_number,
      input  cfg_ext_function_number, cfg_ext_write_data, cfg_ext_write_byte_enable,
      output cfg_ext_read_data, cfg_ext_read_data_valid,
      output mbox_req_data, mbox_req_valid,
      input  mbox_req_ready,
      input  mbox_resp_data, mbox_resp_valid,
      output mbox_resp_ready, irq
   );

   modport master (
      output cfg_ext_read_received, cfg_ext_write_received, cfg_ext_register_number,
      output cfg_ext_function_number, cfg_ext_write_data, cfg_ext_write_byte_enable,
      input  cfg_ext_read_data, cfg_ext_read_data_valid,
      input  mbox_req_data, mbox_req_valid,
      output mbox_req_ready,
      output mbox_resp_data, mbox_resp_valid,
      input  mbox_resp_ready, irq
   );
endinterface

// File: rtl/cndm_pcie_cfg_ext_vsec.sv
// VSEC responder on the PCIe extended config interface: capability header,
// scratch register and a single-outstanding host<->management mailbox.
//
// state  | meaning
// IDLE   | no request outstanding, doorbell accepted
// REQ    | presenting REQ word on mbox_req_*, waiting for ready
// WAIT   | request taken, accepting one response word
module cndm_pcie_cfg_ext_vsec #(
   parameter logic [9:0]  BASE_REG = 10'h0B0,
   parameter logic [11:0] NEXT_PTR = 12'h000,
   parameter logic [15:0] VSEC_ID  = 16'h1234,
   parameter logic [3:0]  VSEC_REV = 4'h0,
   parameter logic [7:0]  FUNC_NUM = 8'd0
) (
   input  logic clk,
   input  logic rst_n,
   cndm_pcie_cfg_ext_vsec_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

   state_t      state, state_nxt;
   logic [31:0] scratch, req_word, resp_word;
   logic        done, ovf;
   logic [31:0] read_data, rd_val;
   logic        read_data_valid, irq;
   logic        req_valid, resp_ready, resp_take;

   logic [9:0]  offset;
   logic        hit, wr_hit, busy;
   logic        wr_scr, wr_req, wr_ctrl;
   logic        doorbell, clr_done, clr_ovf;
   logic [31:0] wd;
   logic [3:0]  be;

   assign wd     = bus.cfg_ext_write_data;
   assign be     = bus.cfg_ext_write_byte_enable;
   assign offset = bus.cfg_ext_register_number - BASE_REG;
   assign hit    = (bus.cfg_ext_register_number >= BASE_REG) && (offset < 10'd8) &&
                   (bus.cfg_ext_function_number == FUNC_NUM);
   assign wr_hit = bus.cfg_ext_write_received && hit;
   assign busy   = (state != ST_IDLE);

   assign wr_scr   = wr_hit && (offset[2:0] == 3'd2);
   assign wr_req   = wr_hit && (offset[2:0] == 3'd3) && !busy;
   assign wr_ctrl  = wr_hit && (offset[2:0] == 3'd4);
   assign doorbell = wr_ctrl && be[0] && wd[0];
   assign clr_done = wr_ctrl && be[1] && wd[8];
   assign clr_ovf  = wr_ctrl && be[1] && wd[9];

   function automatic logic [31:0] merge_be(input logic [31:0] cur, input logic [31:0] nxt,
                                            input logic [3:0] ben);
      logic [31:0] res;
      res = cur;
      for (int i = 0; i < 4; i++)
         if (ben[i]) res[8*i +: 8] = nxt[8*i +: 8];
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      resp_take  = 1'b0;
      case (state)
         ST_IDLE: if (doorbell) state_nxt = ST_REQ;
         ST_REQ: begin
            req_valid = 1'b1;
            if (bus.mbox_req_ready) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            resp_ready = 1'b1;
            if (bus.mbox_resp_valid) begin
               resp_take = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Status bits: a completion landing in the same cycle as a host W1C keeps done set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scratch   <= '0;
         req_word  <= '0;
         resp_word <= '0;
         done      <= 1'b0;
         ovf       <= 1'b0;
         irq       <= 1'b0;
      end else begin
         if (wr_scr) scratch  <= merge_be(scratch, wd, be);
         if (wr_req) req_word <= merge_be(req_word, wd, be);
         if (resp_take) resp_word <= bus.mbox_resp_data;
         if (resp_take)     done <= 1'b1;
         else if (clr_done) done <= 1'b0;
         if (doorbell && busy) ovf <= 1'b1;
         else if (clr_ovf)     ovf <= 1'b0;
         irq <= resp_take;
      end
   end

   always_comb begin
      rd_val = '0;
      if (hit) begin
         case (offset[2:0])
            3'd0:    rd_val = {NEXT_PTR, 4'h1, 16'h000B};
            3'd1:    rd_val = {12'd32, VSEC_REV, VSEC_ID};
            3'd2:    rd_val = scratch;
            3'd3:    rd_val = req_word;
            3'd4:    rd_val = {22'b0, ovf, done, 7'b0, busy};
            3'd5:    rd_val = resp_word;
            default: rd_val = '0;
         endcase
      end
   end

   // Read mux samples pre-write register values, so a same-cycle write is not visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data       <= '0;
         read_data_valid <= 1'b0;
      end else begin
         read_data_valid <= bus.cfg_ext_read_received;
         read_data       <= bus.cfg_ext_read_received ? rd_val : 32'h0;
      end
   end

   assign bus.cfg_ext_read_data       = read_data;
   assign bus.cfg_ext_read_data_valid = read_data_valid;
   assign bus.mbox_req_data           = req_word;
   assign bus.mbox_req_valid          = req_valid;
   assign bus.mbox_resp_ready         = resp_ready;
   assign bus.irq                     = irq;

endmodule

// File: tb/tb_cndm_pcie_cfg_ext_vsec.sv
// Directed bench for the VSEC responder: stimulus pushes expected read data and
// mailbox request words into queues; a negedge monitor pops and compares them.
module tb_cndm_pcie_cfg_ext_vsec;
   localparam logic [9:0] B = 10'h0B0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0, failures = 0, cyc = 0, irq_cnt = 0;

   typedef struct { logic [31:0] data; int cyc; logic [9:0] rn; } rd_exp_t;
   rd_exp_t     sbq[$];
   logic [31:0] mq[$];
   rd_exp_t     mon_e;
   logic [31:0] mon_m;
   logic [31:0] burst_exp [8];

   cndm_pcie_cfg_ext_vsec_if bus();

   cndm_pcie_cfg_ext_vsec #(
      .BASE_REG(10'h0B0), .NEXT_PTR(12'h000), .VSEC_ID(16'h1234),
      .VSEC_REV(4'h0), .FUNC_NUM(8'd0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.cfg_ext_read_data_valid) begin
         checks++;
         if (sbq.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected got=%h cyc=%0d", bus.cfg_ext_read_data, cyc);
         end else begin
            mon_e = sbq.pop_front();
            if (bus.cfg_ext_read_data !== mon_e.data || cyc != mon_e.cyc + 1) begin
               failures++;
               $display("FAIL rd_reg_%h got=%h at cyc %0d want=%h at cyc %0d",
                        mon_e.rn, bus.cfg_ext_read_data, cyc, mon_e.data, mon_e.cyc + 1);
            end
         end
      end else if (rst_n) begin
         checks++;
         if (bus.cfg_ext_read_data !== 32'h0) begin
            failures++;
            $display("FAIL rd_idle_data got=%h want=00000000", bus.cfg_ext_read_data);
         end
      end
      if (bus.mbox_req_valid && bus.mbox_req_ready) begin
         checks++;
         if (mq.size() == 0) begin
            failures++;
            $display("FAIL mbox_unexpected got=%h", bus.mbox_req_data);
         end else begin
            mon_m = mq.pop_front();
            if (bus.mbox_req_data !== mon_m) begin
               failures++;
               $display("FAIL mbox_req_data got=%h want=%h", bus.mbox_req_data, mon_m);
            end
         end
      end
      if (bus.irq) irq_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic cfg(input bit rd, input bit wr, input logic [9:0] rn, input logic [7:0] fn,
                      input logic [31:0] wdat, input logic [3:0] be, input logic [31:0] exp);
      bus.cfg_ext_read_received     = rd;
      bus.cfg_ext_write_received    = wr;
      bus.cfg_ext_register_number   = rn;
      bus.cfg_ext_function_number   = fn;
      bus.cfg_ext_write_data        = wdat;
      bus.cfg_ext_write_byte_enable = be;
      if (rd) sbq.push_back('{data: exp, cyc: cyc, rn: rn});
      tick(1);
      bus.cfg_ext_read_received  = 1'b0;
      bus.cfg_ext_write_received = 1'b0;
   endtask

   task automatic rd(input logic [9:0] rn, input logic [31:0] exp);
      cfg(1'b1, 1'b0, rn, 8'd0, 32'h0, 4'h0, exp);
   endtask

   task automatic wr(input logic [9:0] rn, input logic [31:0] wdat, input logic [3:0] be);
      cfg(1'b0, 1'b1, rn, 8'd0, wdat, be, 32'h0);
   endtask

   task automatic wait_req(input int budget);
      int n = 0;
      while (!bus.mbox_req_valid && n < budget) begin tick(1); n++; end
      check("req_valid_wait", {31'b0, bus.mbox_req_valid}, 32'h1);
   endtask

   task automatic accept();
      bus.mbox_req_ready = 1'b1;
      tick(1);
      bus.mbox_req_ready = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d);
      bus.mbox_resp_data  = d;
      bus.mbox_resp_valid = 1'b1;
      tick(1);
      bus.mbox_resp_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cfg_ext_read_received = 1'b0;
      bus.cfg_ext_write_received = 1'b0;
      bus.cfg_ext_register_number = '0;
      bus.cfg_ext_function_number = '0;
      bus.cfg_ext_write_data = '0;
      bus.cfg_ext_write_byte_enable = '0;
      bus.mbox_req_ready = 1'b0;
      bus.mbox_resp_data = '0;
      bus.mbox_resp_valid = 1'b0;
      burst_exp = '{32'h0001000B, 32'h02001234, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

      tick(3);
      check("rst_rd_valid", {31'b0, bus.cfg_ext_read_data_valid}, 32'h0);
      check("rst_rd_data", bus.cfg_ext_read_data, 32'h0);
      check("rst_req_valid", {31'b0, bus.mbox_req_valid}, 32'h0);
      check("rst_req_data", bus.mbox_req_data, 32'h0);
      check("rst_resp_ready", {31'b0, bus.mbox_resp_ready}, 32'h0);
      check("rst_irq", {31'b0, bus.irq}, 32'h0);
      rst_n = 1'b1;
      tick(1);

      // headers, scratch byte enables, misses, read/write collision
      rd(B + 0, 32'h0001000B);
      rd(B + 1, 32'h02001234);
      wr(B + 2, 32'hDEADBEEF, 4'b0101);
      rd(B + 2, 32'h00AD00EF);
      rd(10'h0B8, 32'h0);
      rd(10'h0AF, 32'h0);
      cfg(1'b1, 1'b0, B, 8'd1, 32'h0, 4'h0, 32'h0);
      cfg(1'b0, 1'b1, B + 2, 8'd1, 32'hFFFFFFFF, 4'hF, 32'h0);
      rd(B + 2, 32'h00AD00EF);
      cfg(1'b1, 1'b1, B + 2, 8'd0, 32'h11223344, 4'hF, 32'h00AD00EF);
      rd(B + 2, 32'h11223344);

      // first mailbox transaction with a stalled request
      wr(B + 3, 32'hCAFE0001, 4'hF);
      mq.push_back(32'hCAFE0001);
      wr(B + 4, 32'h1, 4'hF);
      rd(B + 4, 32'h1);
      repeat (4) begin
         check("req_valid_held", {31'b0, bus.mbox_req_valid}, 32'h1);
         check("req_data_held", bus.mbox_req_data, 32'hCAFE0001);
         tick(1);
      end
      accept();
      check("resp_ready_wait", {31'b0, bus.mbox_resp_ready}, 32'h1);
      respond(32'h000055AA);
      check("irq_pulse", {31'b0, bus.irq}, 32'h1);
      tick(1);
      check("irq_one_cycle", {31'b0, bus.irq}, 32'h0);
      rd(B + 5, 32'h000055AA);
      rd(B + 4, 32'h00000100);
      check("irq_count_1", irq_cnt, 32'd1);

      // response outside WAIT ignored; doorbell+clear; overflow and REQ lock while busy
      respond(32'h0BAD0BAD);
      rd(B + 5, 32'h000055AA);
      wr(B + 3, 32'hA5A50002, 4'hF);
      mq.push_back(32'hA5A50002);
      wr(B + 4, 32'h101, 4'hF);
      rd(B + 4, 32'h001);
      wait_req(10);
      accept();
      wr(B + 4, 32'h1, 4'hF);
      rd(B + 4, 32'h201);
      wr(B + 3, 32'h12345678, 4'hF);
      rd(B + 3, 32'hA5A50002);
      respond(32'h0000BEEF);
      tick(1);
      rd(B + 5, 32'h0000BEEF);
      rd(B + 4, 32'h300);
      wr(B + 4, 32'h300, 4'hF);
      rd(B + 4, 32'h0);
      check("irq_count_2", irq_cnt, 32'd2);

      // completion coinciding with done W1C, then byte-enable gating of W1C
      wr(B + 3, 32'h00000003, 4'hF);
      mq.push_back(32'h00000003);
      wr(B + 4, 32'h1, 4'hF);
      wait_req(10);
      accept();
      bus.mbox_resp_data  = 32'h00000077;
      bus.mbox_resp_valid = 1'b1;
      cfg(1'b0, 1'b1, B + 4, 8'd0, 32'h100, 4'hF, 32'h0);
      bus.mbox_resp_valid = 1'b0;
      rd(B + 4, 32'h100);
      rd(B + 5, 32'h00000077);
      wr(B + 4, 32'h100, 4'b1101);
      rd(B + 4, 32'h100);
      wr(B + 4, 32'h100, 4'b0010);
      rd(B + 4, 32'h0);
      check("irq_count_3", irq_cnt, 32'd3);

      // asynchronous reset while a request is pending and a read response is out
      wr(B + 2, 32'h12345678, 4'hF);
      wr(B + 3, 32'h0BADF00D, 4'hF);
      wr(B + 4, 32'h1, 4'hF);
      wait_req(10);
      bus.cfg_ext_read_received = 1'b1;
      bus.cfg_ext_register_number = B;
      tick(1);
      bus.cfg_ext_read_received = 1'b0;
      check("pre_rst_rd_valid", {31'b0, bus.cfg_ext_read_data_valid}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_req_valid", {31'b0, bus.mbox_req_valid}, 32'h0);
      check("async_rst_rd_valid", {31'b0, bus.cfg_ext_read_data_valid}, 32'h0);
      check("async_rst_rd_data", bus.cfg_ext_read_data, 32'h0);
      check("async_rst_irq", {31'b0, bus.irq}, 32'h0);
      check("async_rst_req_data", bus.mbox_req_data, 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // back-to-back reads across the whole window after reset
      for (int i = 0; i < 8; i++) begin
         bus.cfg_ext_read_received   = 1'b1;
         bus.cfg_ext_register_number = B + 10'(i);
         bus.cfg_ext_function_number = 8'd0;
         sbq.push_back('{data: burst_exp[i], cyc: cyc, rn: B + 10'(i)});
         tick(1);
      end
      bus.cfg_ext_read_received = 1'b0;
      tick(3);
      check("post_rst_req_valid", {31'b0, bus.mbox_req_valid}, 32'h0);
      check("rd_queue_drained", sbq.size(), 32'd0);
      check("mbox_queue_drained", mq.size(), 32'd0);
      check("irq_count_final", irq_cnt, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
